// File: rtl/jam_pkg.sv
// jam_pkg: shared constants and FSM state type for the cost-ROM arbiter
//   NREQ      default requester count
//   MAX_BURST default maximum lookups per grant
//   AW        worker/job address width
//   CW        cost data width
package jam_pkg;
   localparam int NREQ      = 4;
   localparam int MAX_BURST = 8;
   localparam int AW        = 3;
   localparam int CW        = 7;
   typedef enum logic {IDLE, LOCK} state_t;
endpackage

// File: rtl/jam_rr_pick.sv
// jam_rr_pick: round-robin search starting at ptr and wrapping
//   req  in   per-requester request vector
//   ptr  in   index searched first
//   win  out  one-hot winner (0 when req==0)
//   idx  out  winner index (0 when req==0)
module jam_rr_pick #(
   parameter int N = 4,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [PW-1:0] idx
);
   // Scan from the farthest position back to ptr so the closest match wins.
   always_comb begin
      win = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            idx = PW'((int'(ptr) + k) % N);
            win = N'(1) << ((int'(ptr) + k) % N);
         end
      end
   end
endmodule

// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter: round-robin burst arbiter sharing one cost ROM port
//   CLK, RST   clock and asynchronous active-high reset
//   req, last  per-requester lookup request and end-of-burst mark
//   req_w/j    packed 3-bit worker/job indices, requester i at [3i+2:3i]
//   gnt        one-hot grant, transfer when req[i] & gnt[i]
//   W, J       registered ROM address; Cost is the combinational ROM data
//   rsp_valid  one-hot strobe two cycles after a transfer, rsp_cost with it
//   busy       lock held or a lookup still in the pipeline
module jam_cost_arbiter
   import jam_pkg::*;
#(
   parameter int NREQ      = jam_pkg::NREQ,
   parameter int MAX_BURST = jam_pkg::MAX_BURST
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   last,
   input  logic [3*NREQ-1:0] req_w,
   input  logic [3*NREQ-1:0] req_j,
   output logic [NREQ-1:0]   gnt,
   output logic [AW-1:0]     W,
   output logic [AW-1:0]     J,
   input  logic [CW-1:0]     Cost,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [CW-1:0]     rsp_cost,
   output logic              busy
);
   localparam int PW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   state_t          state;
   logic [PW-1:0]   ptr, owner, pick_idx, win;
   logic [BW-1:0]   beats;
   logic [NREQ-1:0] pick_oh, own_oh, tag;
   logic            xfer;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
      return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
   endfunction

   jam_rr_pick #(.N(NREQ)) u_pick (
      .req (req),
      .ptr (ptr),
      .win (pick_oh),
      .idx (pick_idx)
   );

   assign own_oh = NREQ'(1) << owner;
   assign gnt    = RST ? '0 : (state == LOCK) ? (req[owner] ? own_oh : '0) : pick_oh;
   assign win    = (state == LOCK) ? owner : pick_idx;
   assign xfer   = |(req & gnt);
   // tag marks a transfer one cycle ago, rsp_valid one two cycles ago
   assign busy   = (state == LOCK) || |tag || |rsp_valid;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         beats     <= '0;
         W         <= '0;
         J         <= '0;
         tag       <= '0;
         rsp_valid <= '0;
         rsp_cost  <= '0;
      end else begin
         tag       <= xfer ? gnt : '0;
         rsp_valid <= tag;
         if (|tag) rsp_cost <= Cost;
         if (xfer) begin
            W <= req_w[3*win +: 3];
            J <= req_j[3*win +: 3];
            if (state == IDLE) begin
               if (last[win]) ptr <= nxt(win);
               else begin
                  state <= LOCK;
                  owner <= win;
                  beats <= BW'(1);
               end
            end else if (last[owner] || beats == BW'(MAX_BURST - 1)) begin
               state <= IDLE;
               ptr   <= nxt(owner);
               beats <= '0;
            end else beats <= beats + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_jam_cost_arbiter.sv
// tb_jam_cost_arbiter: randomized scoreboard bench against a behavioural arbiter model
module tb_jam_cost_arbiter;
   localparam int N  = 4;
   localparam int MB = 8;

   logic           CLK = 0, RST = 0;
   logic [N-1:0]   req, last, gnt, rsp_valid;
   logic [3*N-1:0] req_w, req_j;
   logic [2:0]     W, J;
   logic [6:0]     Cost, rsp_cost;
   logic           busy;

   always #5 CLK = ~CLK;

   jam_cost_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
      .CLK(CLK), .RST(RST), .req(req), .last(last), .req_w(req_w), .req_j(req_j),
      .gnt(gnt), .W(W), .J(J), .Cost(Cost), .rsp_valid(rsp_valid),
      .rsp_cost(rsp_cost), .busy(busy)
   );

   function automatic logic [6:0] rom(input logic [2:0] w, input logic [2:0] j);
      return 7'(w * 9 + j * 3) ^ {w[1] & j[1], 6'b0};
   endfunction

   assign Cost = rom(W, J);

   typedef struct {int idx; logic [6:0] cost; int due;} exp_t;
   exp_t q[$];

   int tests = 0, fails = 0, cyc = 0;
   int ptr = 0, owner = 0, beats = 0;
   bit locked = 0, h1 = 0, h2 = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input bit rst_i,
                       input logic [3*N-1:0] wv, input logic [3*N-1:0] jv);
      int g;
      @(negedge CLK);
      RST = rst_i; req = r; last = l; req_w = wv; req_j = jv;
      if (rst_i) begin
         q.delete();
         locked = 0; ptr = 0; beats = 0; h1 = 0; h2 = 0;
         #1;
         check("rst_gnt", gnt, 0);
         check("rst_busy", busy, 0);
         check("rst_W", W, 0);
         check("rst_J", J, 0);
         check("rst_cost", rsp_cost, 0);
      end else begin
         #1;
         g = -1;
         if (locked) g = r[owner] ? owner : -1;
         else for (int i = 0; i < N; i++) if (g < 0 && r[(ptr + i) % N]) g = (ptr + i) % N;
         check("gnt", gnt, g < 0 ? 0 : (1 << g));
         check("busy", busy, locked || h1 || h2);
         if (g >= 0) begin
            q.push_back('{g, rom(wv[3*g +: 3], jv[3*g +: 3]), cyc + 2});
            if (!locked) begin
               if (l[g]) ptr = (g + 1) % N;
               else begin
                  locked = 1; owner = g; beats = 1;
               end
            end else begin
               beats++;
               if (l[owner] || beats == MB) begin
                  locked = 0; ptr = (owner + 1) % N;
               end
            end
         end
         h2 = h1; h1 = (g >= 0);
      end
   endtask

   task automatic rstep(input logic [N-1:0] r, input logic [N-1:0] l);
      step(r, l, 0, 12'($urandom), 12'($urandom));
   endtask

   initial begin
      logic [N-1:0] ev;
      forever begin
         @(negedge CLK);
         #2;
         ev = (q.size() > 0 && q[0].due == cyc) ? N'(1) << q[0].idx : '0;
         check("rsp_valid", rsp_valid, ev);
         if (ev != 0) begin
            check("rsp_cost", rsp_cost, q[0].cost);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      req = 0; last = 0; req_w = 0; req_j = 0;
      #1 RST = 1;
      repeat (3) step(0, 0, 1, 0, 0);
      // single beat: worker 3, job 5
      step(4'b0001, 4'b0001, 0, 12'd3, 12'd5);
      repeat (3) rstep(0, 0);
      // burst of 8 with a competing requester
      repeat (2) step(0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) rstep(4'b0011, (i == 7) ? 4'b0001 : 4'b0000);
      repeat (3) rstep(4'b0011, 4'b0011);
      // forced release: no last for 10 beats, alone then with requester 1
      for (int i = 0; i < 10; i++) rstep(4'b0001, 4'b0000);
      for (int i = 0; i < 10; i++) rstep(4'b0001, 4'b0000);
      for (int i = 0; i < 10; i++) rstep(4'b0011, 4'b0010);
      repeat (3) rstep(0, 0);
      // fairness
      repeat (2) step(0, 0, 1, 0, 0);
      repeat (8) rstep(4'b1111, 4'b1111);
      // owner stall
      rstep(4'b0001, 4'b0000);
      rstep(4'b0001, 4'b0000);
      repeat (3) rstep(4'b0100, 4'b0000);
      rstep(4'b0101, 4'b0000);
      rstep(4'b0101, 4'b0001);
      rstep(4'b0101, 4'b0101);
      // reset one cycle after a transfer in a burst
      rstep(4'b0010, 4'b0000);
      step(4'b0010, 4'b0000, 1, 0, 0);
      step(4'b0000, 4'b0000, 1, 0, 0);
      rstep(4'b1100, 4'b0000);
      rstep(4'b1100, 4'b1111);
      // random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(199) == 0) step(4'($urandom), 4'($urandom), 1, 0, 0);
         else rstep(4'($urandom) | 4'($urandom), 4'($urandom) & 4'($urandom));
      end
      repeat (4) rstep(0, 0);
      check("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
